// File: rtl/uart_cmd_seq_if.sv
// uart_cmd_seq_if: receiver byte handshake plus command output of uart_cmd_seq.
interface uart_cmd_seq_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        tmo;
    modport master (output rx_rdy, rx_data, clr_cmd_rdy, input clr_rx_rdy, cmd, cmd_rdy, tmo);
    modport slave (input rx_rdy, rx_data, clr_cmd_rdy, output clr_rx_rdy, cmd, cmd_rdy, tmo);
endinterface

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles two received UART bytes into a 16-bit command {first, second}.
// Define UART_CMD_SEQ_TMO_EN to build the inter-byte timeout; otherwise WAIT_LO waits forever.
module uart_cmd_seq #(
    parameter int TMO_CYCLES = 52080
) (
    input logic clk,
    input logic rst,
    uart_cmd_seq_if.slave bus
);
    typedef enum logic {WAIT_HI, WAIT_LO} state_t;
    state_t state, state_nx;
    logic [7:0] hi;
    logic guard, take, take_hi, take_lo, expire;
    if (TMO_CYCLES < 1 || TMO_CYCLES > 65536) begin : g_tmo_range
        $error("TMO_CYCLES must fit the 16-bit timeout counter");
    end
    always_ff @(posedge clk) state <= rst ? WAIT_HI : state_nx;
    always_comb state_nx = take_hi ? WAIT_LO : (take_lo || expire) ? WAIT_HI : state;
    // rx_rdy is ignored while clr_rx_rdy is out and for one cycle after, covering receiver clear latency
    always_comb begin
        take    = bus.rx_rdy && !bus.clr_rx_rdy && !guard;
        take_hi = take && state == WAIT_HI;
        take_lo = take && state == WAIT_LO;
    end
`ifdef UART_CMD_SEQ_TMO_EN
    logic [15:0] cnt;
    assign expire = state == WAIT_LO && !take && cnt == 16'(TMO_CYCLES - 1);
    always_ff @(posedge clk) begin
        cnt     <= (rst || state != WAIT_LO || take || expire) ? '0 : cnt + 16'd1;
        bus.tmo <= !rst && expire;
    end
`else
    assign expire  = 1'b0;
    assign bus.tmo = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            hi             <= '0;
            guard          <= 1'b0;
            bus.clr_rx_rdy <= 1'b0;
            bus.cmd        <= '0;
            bus.cmd_rdy    <= 1'b0;
        end else begin
            guard          <= bus.clr_rx_rdy;
            bus.clr_rx_rdy <= take;
            if (take_hi) hi <= bus.rx_data;
            if (take_lo) bus.cmd <= {hi, bus.rx_data};
            bus.cmd_rdy    <= take_lo || (bus.cmd_rdy && !bus.clr_cmd_rdy && !take_hi);
        end
    end
endmodule
